// File: rtl/pipe_consumer_checker_pkg.sv
// Shared types and constants for the two-lane pipeline consumer/checker.
package pipe_consumer_checker_pkg;

  typedef enum logic {
    SYNC  = 1'b0,
    CHECK = 1'b1
  } lane_state_e;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic        LANE1_PARITY = 1'b0;
  localparam logic        LANE2_PARITY = 1'b1;
  localparam int          DATA_W_DEF   = 32;

  // Right-shifting Galois LFSR, taps 16,14,13,11.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/pipe_consumer_checker_lane.sv
// Per-lane sequence checker: SYNC/CHECK FSM, expected register, saturating counters,
// and the optional LFSR stall generator (PIPE_CONSUMER_LFSR_STALL_EN).
//
// state | meaning
// SYNC  | waiting for a beat of the lane's parity to lock onto
// CHECK | comparing each accepted beat with the running expected value
module pipe_lane_checker
  import pipe_consumer_checker_pkg::*;
#(
  parameter int          DATA_W       = DATA_W_DEF,
  parameter int          STEP         = 2,
  parameter int          OFFSET       = 0,
  parameter logic        PARITY       = LANE1_PARITY,
  parameter logic [15:0] SEED         = 16'hACE1,
  parameter int          STALL_THRESH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_flush,
  input  logic              i_done,
  output logic              o_stall,
  output logic [31:0]       o_match_count,
  output logic [15:0]       o_err_count
);

  localparam logic [DATA_W-1:0] STEP_C   = DATA_W'(STEP);
  localparam logic [DATA_W-1:0] OFFSET_C = DATA_W'(OFFSET);
  localparam logic [DATA_W-1:0] EXP_INIT = {{(DATA_W-1){1'b0}}, PARITY} + OFFSET_C;

  lane_state_e       r_state, w_state_nxt;
  logic [DATA_W-1:0] r_expected, w_expected_nxt;
  logic [31:0]       r_match_count, w_match_nxt, w_match_inc;
  logic [15:0]       r_err_count, w_err_nxt, w_err_inc;
  logic              w_stall;
  logic              w_accept;
  logic              w_parity_ok;

  assign w_accept    = i_valid & ~w_stall;
  // Parity of (data - OFFSET) only depends on the low bits of each operand.
  assign w_parity_ok = ((i_data[0] ^ OFFSET_C[0]) == PARITY);
  assign w_match_inc = (r_match_count == 32'hFFFF_FFFF) ? r_match_count : r_match_count + 32'd1;
  assign w_err_inc   = (r_err_count == 16'hFFFF) ? r_err_count : r_err_count + 16'd1;

  always_comb begin
    w_state_nxt    = r_state;
    w_expected_nxt = r_expected;
    w_match_nxt    = r_match_count;
    w_err_nxt      = r_err_count;
    if (i_flush) begin
      w_state_nxt = SYNC;
    end else if (w_accept) begin
      case (r_state)
        SYNC: begin
          if (w_parity_ok) begin
            w_expected_nxt = i_data + STEP_C;
            w_match_nxt    = w_match_inc;
            w_state_nxt    = CHECK;
          end else begin
            w_err_nxt = w_err_inc;
          end
        end
        CHECK: begin
          // Re-basing on the observed beat keeps a single drop/duplicate to one error.
          w_expected_nxt = i_data + STEP_C;
          if (i_data == r_expected) w_match_nxt = w_match_inc;
          else                      w_err_nxt   = w_err_inc;
        end
        default: w_state_nxt = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= SYNC;
      r_expected    <= EXP_INIT;
      r_match_count <= '0;
      r_err_count   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_expected    <= w_expected_nxt;
      r_match_count <= w_match_nxt;
      r_err_count   <= w_err_nxt;
    end
  end

`ifdef PIPE_CONSUMER_LFSR_STALL_EN
  logic [15:0] r_lfsr;
  logic        r_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr  <= SEED;
      r_stall <= 1'b0;
    end else begin
      r_lfsr  <= lfsr_next(r_lfsr);
      r_stall <= ~i_done && ({1'b0, r_lfsr[3:0]} < 5'(STALL_THRESH));
    end
  end

  assign w_stall = r_stall;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{SEED, 5'(STALL_THRESH), i_done};
  assign w_stall      = 1'b0;
`endif

  assign o_stall       = w_stall;
  assign o_match_count = r_match_count;
  assign o_err_count   = r_err_count;

endmodule

// File: rtl/pipe_consumer_checker.sv
// Sink-side checker for the two-lane producer: per-lane sequence checkers plus
// sticky done/error aggregation. Stalls exist only with PIPE_CONSUMER_LFSR_STALL_EN.
module pipe_consumer_checker
  import pipe_consumer_checker_pkg::*;
#(
  parameter int          DATA_W       = DATA_W_DEF,
  parameter int          STEP         = 2,
  parameter int          OFFSET       = 0,
  parameter int          NUM_CHECKS   = 1000,
  parameter logic [15:0] LFSR_SEED1   = 16'hACE1,
  parameter logic [15:0] LFSR_SEED2   = 16'h1D2B,
  parameter int          STALL_THRESH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        out_valid,
  input  logic [DATA_W-1:0] pipeline1_outputs,
  input  logic [DATA_W-1:0] pipeline2_outputs,
  input  logic              flush_1,
  input  logic              flush_2,
  output logic              stall_1,
  output logic              stall_2,
  output logic [31:0]       match_count_1,
  output logic [31:0]       match_count_2,
  output logic [15:0]       err_count_1,
  output logic [15:0]       err_count_2,
  output logic              error,
  output logic              done
);

  logic r_done;

  pipe_lane_checker #(
    .DATA_W(DATA_W), .STEP(STEP), .OFFSET(OFFSET), .PARITY(LANE1_PARITY),
    .SEED(LFSR_SEED1), .STALL_THRESH(STALL_THRESH)
  ) u_lane1 (
    .clk(clk), .reset(reset), .i_valid(out_valid[0]), .i_data(pipeline1_outputs),
    .i_flush(flush_1), .i_done(r_done), .o_stall(stall_1),
    .o_match_count(match_count_1), .o_err_count(err_count_1)
  );

  pipe_lane_checker #(
    .DATA_W(DATA_W), .STEP(STEP), .OFFSET(OFFSET), .PARITY(LANE2_PARITY),
    .SEED(LFSR_SEED2), .STALL_THRESH(STALL_THRESH)
  ) u_lane2 (
    .clk(clk), .reset(reset), .i_valid(out_valid[1]), .i_data(pipeline2_outputs),
    .i_flush(flush_2), .i_done(r_done), .o_stall(stall_2),
    .o_match_count(match_count_2), .o_err_count(err_count_2)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_done <= 1'b0;
    else       r_done <= r_done || ((match_count_1 >= 32'(NUM_CHECKS)) &&
                                    (match_count_2 >= 32'(NUM_CHECKS)));
  end

  // Error counters saturate rather than wrap, so a nonzero count is already sticky.
  assign error = (err_count_1 != 16'd0) || (err_count_2 != 16'd0);
  assign done  = r_done;

endmodule

// File: doc/pipe_consumer_checker.md
Name: pipe_consumer_checker

Overview:
Sink-side counterpart to the two-lane stimulus producer, sitting at the output end of both pipelines.
- Consumes per-lane output beats and checks each lane against its expected arithmetic sequence:
  - lane 1: even stream starting at 0;
  - lane 2: odd stream starting at 1;
  - both step 2, plus a fixed pipeline offset.
- Generates per-lane stall backpressure toward the producer and pipelines.
- Tolerates flushes by resynchronising, and reports match/error counts plus a done flag.

Parameters:
- DATA_W, 32, lane data width.
- STEP, 2, expected increment between consecutive consumed beats.
- OFFSET, 0, constant the pipeline adds to each input; expected = producer value + OFFSET (mod 2^DATA_W).
- NUM_CHECKS, 1000, matched beats per lane required before done.
- LFSR_SEED1, 16'hACE1, lane-1 stall LFSR seed (must be non-zero).
- LFSR_SEED2, 16'h1D2B, lane-2 stall LFSR seed (must be non-zero).
- STALL_THRESH, 4, stall when LFSR[3:0] < STALL_THRESH (0 = never, 16 = always).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- out_valid  in  2  bit0 lane 1, bit1 lane 2 output valid
- pipeline1_outputs  in  DATA_W  lane-1 output data
- pipeline2_outputs  in  DATA_W  lane-2 output data
- flush_1  in  1  lane-1 flush, as driven to the pipeline
- flush_2  in  1  lane-2 flush, as driven to the pipeline
- stall_1  out  1  lane-1 stall, registered
- stall_2  out  1  lane-2 stall, registered
- match_count_1  out  32  lane-1 matched beats
- match_count_2  out  32  lane-2 matched beats
- err_count_1  out  16  lane-1 mismatches, saturating at 16'hFFFF
- err_count_2  out  16  lane-2 mismatches, saturating at 16'hFFFF
- error  out  1  sticky; set on any mismatch
- done  out  1  sticky; both match counts >= NUM_CHECKS

Behaviour:
- Reset values:
  - stall_1, stall_2 = 0;
  - all counts = 0;
  - error = 0, done = 0;
  - lane states = SYNC;
  - expected registers = 0 / 1 (+ OFFSET);
  - LFSRs = their seeds.
- Beat accept: lane n consumes a beat in a cycle where out_valid[n]=1 and registered stall_n=0. A valid beat arriving while stall_n=1 is ignored, not checked.
- Per-lane FSM:
  - SYNC (after reset or flush):
    - first accepted beat with parity (data - OFFSET) matching the lane parity (even lane 1, odd lane 2) sets expected = data + STEP, increments match, goes to CHECK;
    - a wrong-parity beat counts as an error and stays in SYNC.
  - CHECK:
    - data == expected: match++;
    - else: err++ and error=1, then re-base expected = data + STEP (a single dropped/duplicated beat yields exactly one error);
    - in both cases expected advances by STEP (mod 2^DATA_W).
  - flush_n=1 in any state → SYNC next cycle. A beat accepted in the same cycle as the flush is discarded: no count change.
- Wrap-around: expected and data are compared modulo 2^DATA_W; 32'hFFFFFFFF + 2 → 32'h1.
- Stall generation:
  - Each lane has a 16-bit Galois LFSR (taps 16,14,13,11) advancing every cycle.
  - stall_n <= (LFSR[3:0] < STALL_THRESH).
  - Both stalls are forced 0 once done=1.
- done is registered and asserts the cycle after the second lane reaches NUM_CHECKS. Counts keep updating after done; done never clears until reset.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); no partial counts are retained.
- Match counters saturate at 32'hFFFFFFFF.

Optional Feature:
- Macro: PIPE_CONSUMER_LFSR_STALL_EN.
- Defined: LFSR stall generation as specified.
- Undefined: no LFSRs; stall_1 and stall_2 tied to 0; STALL_THRESH and the seeds are unused; all checking is unchanged.

Decomposition:
- Shared package holds:
  - lane-state enum {SYNC, CHECK};
  - LFSR tap constant 16'hB400;
  - lane parity constants (LANE1_PARITY=0, LANE2_PARITY=1);
  - DATA_W default.
- One sub-module, pipe_lane_checker: per-lane FSM, expected register, counters, optional LFSR. It is instantiated twice with the parity/seed as parameters. The top level adds the done/error aggregation.

Test Plan:
- STALL_THRESH=0: lane 1 fed 0,2,4,…; lane 2 fed 1,3,5,…, one beat per cycle, OFFSET=0 → match counts increment every cycle, err_count_1 = err_count_2 = 0, done the cycle after NUM_CHECKS beats per lane.
- Lane 1 fed 0,2,6,8 → err_count_1=1, error=1, match_count_1=3 (0,2,8 match after the re-base on 6).
- flush_1 pulse with a valid beat of 10 in the same cycle, then beats 40,42 → the 10 is discarded, SYNC locks on 40, match_count_1 += 2, no errors.
- SYNC with a lane-2 first beat of 4 (wrong parity) → err_count_2=1, lane stays in SYNC, next beat 5 locks.
- Lane 1 expected 32'hFFFFFFFE, fed 32'hFFFFFFFE then 32'h0 → both match (wrap-around).
- STALL_THRESH=8 with the feature on → stalls asserted ~50%, no valid beat is checked while stall=1; a reset asserted mid-run zeroes all outputs asynchronously.
